// File: rtl/gate_checker.sv
// Gate checker: walks a 2-input gate under test through all four {a,b} vectors and compares out against EXPECTED.
// Optional macro GATE_CHECKER_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_checker #(
   parameter logic [3:0]  EXPECTED      = 4'b0110,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       out,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [1:0] vector_idx
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // The counter counts down to zero, so a load of SETTLE_CYCLES-1 yields SETTLE_CYCLES settle cycles.
   localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   function automatic logic vector_mismatch(input logic [1:0] idx, input logic observed);
      return (observed != EXPECTED[idx]);
   endfunction

   state_t     state_r, state_s;
   logic [3:0] cnt_r, cnt_s;
   logic [1:0] idx_r, idx_s;
   logic       a_r, a_s;
   logic       b_r, b_s;
   logic       busy_r, busy_s;
   logic       done_r, done_s;
   logic       pass_r, pass_s;
   logic [3:0] mask_r, mask_s;
   logic       mismatch_s;

   // Next-state and next-output computation for the run sequencer
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      idx_s      = idx_r;
      a_s        = a_r;
      b_s        = b_r;
      pass_s     = pass_r;
      mask_s     = mask_r;
      done_s     = 1'b0;
      mismatch_s = vector_mismatch(idx_r, out);
      case (state_r)
         IDLE: begin
            if (start) begin
               idx_s   = 2'd0;
               a_s     = 1'b0;
               b_s     = 1'b0;
               mask_s  = 4'b0000;
               pass_s  = 1'b0;
               cnt_s   = RELOAD;
               state_s = SETTLE;
            end else begin
               state_s = IDLE;
            end
         end
         SETTLE: begin
            if (cnt_r == 4'd0) begin
               state_s = SAMPLE;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         SAMPLE: begin
            mask_s[idx_r] = mismatch_s;
            if ((idx_r == 2'd3) || (STOP_ON_FAIL && mismatch_s)) begin
               // Vector index is kept so an early abort reports the failing vector.
               a_s     = 1'b0;
               b_s     = 1'b0;
               done_s  = 1'b1;
               pass_s  = (mask_s == 4'b0000);
               state_s = DONE;
            end else begin
               idx_s      = idx_r + 2'd1;
               {a_s, b_s} = idx_r + 2'd1;
               cnt_s      = RELOAD;
               state_s    = SETTLE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         idx_r   <= 2'd0;
         a_r     <= 1'b0;
         b_r     <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
         mask_r  <= 4'b0000;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         a_r     <= a_s;
         b_r     <= b_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         pass_r  <= pass_s;
         mask_r  <= mask_s;
      end
   end

   assign a          = a_r;
   assign b          = b_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign pass       = pass_r;
   assign fail_mask  = mask_r;
   assign vector_idx = idx_r;

endmodule
